spi_transfer: RTL and testbench



---
 rtl/spi_transfer.sv | 143 ++++++++++++++
 tb/tb_spi_transfer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transfer.sv
// Full-duplex mode-3 SPI master: loads a parallel word, shifts it out MSB-first
// while capturing MISO, then presents the received word with a one-cycle done pulse.
module spi_transfer #(
  parameter int SIZE     = 40,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            start_in,
  input  logic [SIZE-1:0] data_in,
  output logic [SIZE-1:0] data_out,
  output logic            busy_out,
  output logic            done_out,
  output logic            sclk_out,
  output logic            cs_n_out,
  output logic            mosi_out,
  input  logic            miso_in
);

  localparam int CNT_MAX = (CS_SETUP > CLK_DIV) ?
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD) :
                           ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD);
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam int BIT_W = $clog2(SIZE) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SIZE-2:0]   tx_sr;
  logic [SIZE-1:0]   rx_sr;
  logic              phase_end;
  logic              last_bit;

  // Request handshake: start_in acts as valid, !busy_out as ready; a request is
  // accepted on the clk_in edge where both are high and the word is captured then.
  assign last_bit = (bit_cnt == BIT_W'(SIZE - 1));

  always_comb begin
    phase_end = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_in) state_nxt = SETUP;
      end
      SETUP: begin
        phase_end = (cnt == CNT_W'(CS_SETUP - 1));
        if (phase_end) state_nxt = SHIFT;
      end
      SHIFT: begin
        phase_end = (cnt == CNT_W'(CLK_DIV - 1));
        if (phase_end && sclk_out && last_bit) state_nxt = HOLD;
      end
      HOLD: begin
        phase_end = (cnt == CNT_W'(CS_HOLD - 1));
        if (phase_end) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Control outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cs_n_out <= 1'b1;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      cnt      <= '0;
    end else begin
      cs_n_out <= !(state_nxt inside {SETUP, SHIFT, HOLD});
      busy_out <= (state_nxt != IDLE);
      done_out <= (state_nxt == DONE);
      if ((state_nxt != state) || phase_end) cnt <= '0;
      else if (state inside {SETUP, SHIFT, HOLD}) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sclk_out <= 1'b1;
      mosi_out <= 1'b0;
      data_out <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_in) begin
            tx_sr    <= data_in[SIZE-2:0];
            mosi_out <= data_in[SIZE-1];
            bit_cnt  <= '0;
          end
        end
        SETUP: begin
          if (phase_end) sclk_out <= 1'b0;
        end
        SHIFT: begin
          if (phase_end) begin
            if (!sclk_out) begin
              sclk_out <= 1'b1;
              rx_sr    <= {rx_sr[SIZE-2:0], miso_in};
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // The final high phase leaves SCLK high for the hold window.
              if (!last_bit) begin
                sclk_out <= 1'b0;
                mosi_out <= tx_sr[SIZE-2];
                tx_sr    <= tx_sr << 1;
              end
            end
          end
        end
        HOLD: begin
          if (phase_end) data_out <= rx_sr;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_transfer.sv
// Self-checking bench for spi_transfer: a 40-bit default instance driven with random
// words against a slave model, plus two small loopback instances for edge configurations.
module tb_spi_transfer;

  localparam int N   = 40;
  localparam int CD  = 4;
  localparam int SU  = 2;
  localparam int HO  = 2;
  localparam int LAT = SU + 2 * CD * N + HO;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- main instance ----------------
  logic          start;
  logic [N-1:0]  data;
  wire  [N-1:0]  data_out;
  wire           busy, done, sclk, cs_n, mosi;
  logic          miso;

  spi_transfer #(.SIZE(N), .CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HO)) u_dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .data_in(data),
    .data_out(data_out), .busy_out(busy), .done_out(done), .sclk_out(sclk),
    .cs_n_out(cs_n), .mosi_out(mosi), .miso_in(miso)
  );

  // ---------------- small loopback instances ----------------
  logic [1:0] sm_start;
  logic [7:0] sm_data_b;
  logic [1:0] sm_data_c;
  wire  [7:0] sm_dout_b;
  wire  [1:0] sm_dout_c;
  wire  [1:0] sm_busy, sm_done, sm_sclk, sm_cs_n, sm_mosi;

  spi_transfer #(.SIZE(8), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) u_dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(sm_start[0]), .data_in(sm_data_b),
    .data_out(sm_dout_b), .busy_out(sm_busy[0]), .done_out(sm_done[0]),
    .sclk_out(sm_sclk[0]), .cs_n_out(sm_cs_n[0]), .mosi_out(sm_mosi[0]),
    .miso_in(sm_mosi[0])
  );

  spi_transfer #(.SIZE(2), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut_c (
    .clk_in(clk), .rst_in(rst), .start_in(sm_start[1]), .data_in(sm_data_c),
    .data_out(sm_dout_c), .busy_out(sm_busy[1]), .done_out(sm_done[1]),
    .sclk_out(sm_sclk[1]), .cs_n_out(sm_cs_n[1]), .mosi_out(sm_mosi[1]),
    .miso_in(sm_mosi[1])
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- scoreboard / slave model ----------------
  logic [N-1:0] exp_rx_q[$];
  logic [N-1:0] exp_tx_q[$];
  int           cs_gap_q[$];
  int           busy_gap_q[$];
  logic [N-1:0] slave_word = '0;
  logic [N-1:0] slave_rx   = '0;
  int  cyc = 0, t_acc = 0, rises = 0, cs_low = 0, last_rise = -1, period_bad = 0;
  int  cs_high_run = 0, busy_low_run = 0, glitch = 0, frames_done = 0;
  logic sclk_q = 1'b1, cs_q = 1'b1, after_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sclk_q     = 1'b1;
      cs_q       = 1'b1;
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        after_done = 1'b0;
      end
      if (!cs_n && cs_q) begin
        t_acc      = cyc;
        rises      = 0;
        cs_low     = 0;
        last_rise  = -1;
        period_bad = 0;
        cs_gap_q.push_back(cs_high_run);
        busy_gap_q.push_back(busy_low_run);
      end
      if (cs_n) cs_high_run++; else cs_high_run = 0;
      if (!busy) busy_low_run++; else busy_low_run = 0;
      if (!cs_n) cs_low++;
      if (sclk && !sclk_q) begin
        slave_rx = {slave_rx[N-2:0], mosi};
        rises++;
        if (last_rise >= 0 && (cyc - last_rise) != 2 * CD) period_bad++;
        last_rise = cyc;
      end
      if (cs_n && !sclk) glitch++;
      if (done) begin
        check("latency", cyc - t_acc, LAT);
        check("sclk_rises", rises, N);
        check("sclk_period", period_bad, 0);
        check("cs_low_cycles", cs_low, LAT);
        check("sclk_idle_low", glitch, 0);
        if (exp_rx_q.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          check("data_out", data_out, exp_rx_q.pop_front());
          check("slave_capture", slave_rx, exp_tx_q.pop_front());
        end
        frames_done++;
        after_done = 1'b1;
      end
      sclk_q = sclk;
      cs_q   = cs_n;
    end
    miso = (rises < N) ? slave_word[N-1-rises] : 1'b0;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [N-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    check("idle_wait", busy, 1'b0);
  endtask

  task automatic xfer(input logic [N-1:0] d, input logic [N-1:0] w, input bit inject);
    int base;
    wait_idle();
    base = frames_done;
    @(negedge clk);
    data       = d;
    slave_word = w;
    start      = 1'b1;
    exp_tx_q.push_back(d);
    exp_rx_q.push_back(w);
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1'b1);
    check("accept_cs_n", cs_n, 1'b0);
    check("accept_mosi", mosi, d[N-1]);
    data = rand_word();
    if (inject) begin
      for (int i = 0; i < 200 && rises < 2; i++) @(negedge clk);
      data  = ~d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < LAT + 50 && frames_done == base; i++) @(negedge clk);
    check("done_seen", frames_done - base, 1);
    @(negedge clk);
    check("mosi_hold", mosi, d[0]);
    check("data_out_hold", data_out, w);
  endtask

  task automatic run_small(input int idx, input int size, input int cd, input int su,
                           input int ho, input logic [7:0] d);
    int t, r;
    logic pq, fin;
    logic [7:0] cap;
    logic [7:0] dout;
    t = 0; r = 0; cap = '0; fin = 1'b0;
    @(negedge clk);
    if (idx == 0) sm_data_b = d; else sm_data_c = d[1:0];
    sm_start[idx] = 1'b1;
    @(negedge clk);
    sm_start[idx] = 1'b0;
    pq = sm_sclk[idx];
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      t++;
      if (sm_sclk[idx] && !pq) begin
        r++;
        cap = {cap[6:0], sm_mosi[idx]};
      end
      pq  = sm_sclk[idx];
      fin = sm_done[idx];
    end
    dout = (idx == 0) ? sm_dout_b : {6'b0, sm_dout_c};
    check("small_done_seen", fin, 1'b1);
    check("small_latency", t, su + 2 * cd * size + ho);
    check("small_rises", r, size);
    check("small_mosi_seq", cap, d);
    check("small_loopback", dout, d);
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] d, w;
    int base, done_cnt;
    rst = 1'b1; start = 1'b0; data = '0;
    sm_start = '0; sm_data_b = '0; sm_data_c = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data_out", data_out, '0);

    xfer(40'hFF_0000_00FF, 40'h12_3456_789A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      xfer(rand_word(), rand_word(), i == 2);
    end

    // back-to-back frames with start held high
    wait_idle();
    cs_gap_q.delete();
    busy_gap_q.delete();
    d = rand_word();
    w = rand_word();
    for (int i = 0; i < 3; i++) begin
      exp_tx_q.push_back(d);
      exp_rx_q.push_back(w);
    end
    base = frames_done;
    @(negedge clk);
    data = d; slave_word = w; start = 1'b1;
    for (int i = 0; i < 4 * LAT && frames_done < base + 3; i++) @(negedge clk);
    start = 1'b0;
    check("b2b_frames", frames_done - base, 3);
    check("b2b_accepts", cs_gap_q.size(), 3);
    if (cs_gap_q.size() == 3) begin
      check("b2b_cs_gap1", cs_gap_q[1], 2);
      check("b2b_cs_gap2", cs_gap_q[2], 2);
      check("b2b_busy_gap1", busy_gap_q[1], 1);
      check("b2b_busy_gap2", busy_gap_q[2], 1);
    end

    // reset in the middle of the shift phase
    wait_idle();
    @(negedge clk);
    data = rand_word(); slave_word = rand_word(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && rises < 3; i++) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_sclk", sclk, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_data_out", data_out, '0);
    check("abort_done", done, 1'b0);
    check("abort_mosi", mosi, 1'b0);
    exp_tx_q.delete();
    exp_rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    xfer(rand_word(), rand_word(), 1'b0);

    // small configurations in loopback
    run_small(0, 8, 2, 2, 2, 8'hA5);
    run_small(0, 8, 2, 2, 2, 8'($urandom_range(0, 255)));
    run_small(1, 2, 1, 1, 1, 8'h02);
    run_small(1, 2, 1, 1, 1, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
